// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, command/response codes and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  // 100 MHz system clock: 120 us inhibit, 20 ms inter-edge watchdog
  localparam int unsigned PS2_INHIBIT_CYCLES = 12000;
  localparam int unsigned PS2_TIMEOUT_CYCLES = 2000000;
  localparam int unsigned PS2_FILTER_LEN     = 8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines and debounces the clock line; emits a one-cycle
// strobe on each accepted falling edge of the PS/2 clock.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_filt_o,
  output logic data_sync_o,
  output logic fall_o
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fall_q;

  // A new level is accepted only after FILTER_LEN consecutive differing samples
  always_comb begin
    clk_filt_d = clk_filt_q;
    flt_cnt_d  = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_sync_q[1];
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      flt_cnt_q   <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_filt_q  <= clk_filt_d;
      flt_cnt_q   <= flt_cnt_d;
      fall_q      <= clk_filt_q & ~clk_filt_d;
    end
  end

  assign clk_filt_o  = clk_filt_q;
  assign data_sync_o = data_sync_q[1];
  assign fall_o      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, shifts out one command byte
// with odd parity on device clock edges and checks the device ACK bit.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  ps2_tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          ack_ok_q, ack_ok_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic clk_filt, data_sync, fall, wd_expire;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_filt_o (clk_filt),
    .data_sync_o(data_sync),
    .fall_o     (fall)
  );

  assign wd_expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_d     = par_q;
    ack_ok_d  = ack_ok_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          data_d   = tx_data;
          par_d    = odd_parity(tx_data);
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        // Start bit goes out one cycle before the clock line is released
        if (data_oe_q) begin
          clk_oe_d  = 1'b0;
          cnt_d     = '0;
          bit_idx_d = 4'd0;
          state_d   = ST_SEND;
        end else if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SEND: begin
        if (fall) begin
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q < 4'd8) begin
            data_oe_d = ~data_q[bit_idx_q[2:0]];
          end else if (bit_idx_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
        end else if (wd_expire) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACK: begin
        if (fall) begin
          cnt_d    = '0;
          ack_ok_d = ~data_sync;
          state_d  = ST_WAIT_IDLE;
        end else if (wd_expire) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_filt && data_sync) begin
          done_d  = ack_ok_q;
          err_d   = ~ack_ok_q;
          state_d = ST_IDLE;
        end else if (wd_expire) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 4'd0;
      data_q    <= 8'd0;
      par_q     <= 1'b0;
      ack_ok_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_q     <= par_d;
      ack_ok_q  <= ack_ok_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
